alu_div: RTL
============

# alu_div

Sequential restoring divider that sits beside the combinational `alu` in the execution unit. It provides the DIVU/DIV operations, the counterpart of the ALU's single-cycle MULU/MUL. The microcode sequencer issues a one-cycle `start` and stalls until `done`. The block then returns quotient, remainder and an error indication, which the sequencer turns into the divide-error trap.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; operands sampled on the same edge
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU
- `wide`  in  1  1 = 32/16 division, 0 = 16/8 division
- `dividend`  in  32  wide: [31:0]; byte: [15:0] used, [31:16] ignored
- `divisor`  in  16  wide: [15:0]; byte: [7:0] used, [15:8] ignored
- `busy`  out  1  division in progress
- `done`  out  1  one-cycle completion pulse
- `div_error`  out  1  valid with `done`; divide by zero or quotient overflow
- `quotient`  out  16  byte mode: result in [7:0], [15:8] = 0
- `remainder`  out  16  byte mode: result in [7:0], [15:8] = 0

## Operation
- States: IDLE, CALC, FIX, DONE. Reset enters IDLE with all outputs 0.
- IDLE or DONE with `start` = 1:
  - Latch the mode bits and the operand magnitudes. In signed mode, record the dividend sign and the quotient sign (dividend sign XOR divisor sign).
  - If the divisor field is 0, go to DONE with the error flag set.
  - If the high half of the dividend magnitude is >= the divisor magnitude, go to DONE with the error flag set. This is the early overflow check; the high half is [31:16] wide, [15:8] byte.
  - Otherwise load the iteration counter with N (16 wide, 8 byte) and go to CALC.
- CALC: one restoring step per cycle.
  - Shift the partial remainder left, taking in the next dividend bit.
  - Trial-subtract the divisor magnitude. Keep the difference if it is non-negative, and shift the result bit into the quotient.
  - The counter decrements each step; go to FIX when it reaches 0.
- FIX (signed mode only):
  - Negate the quotient if the quotient sign is 1. Negate the remainder if the dividend sign is 1.
  - Quotient truncates toward zero; remainder carries the sign of the dividend.
  - Range check, overflow flags the error:
    - wide quotient must be within -32768..32767
    - byte quotient must be within -128..127
- DONE:
  - `done` = 1 for exactly one cycle.
  - On success, update `quotient`/`remainder` on entry to DONE.
  - On error, both keep their previous values and `div_error` = 1. `div_error` is cleared on the next accepted `start`.
  - Return to IDLE unless `start` is sampled.
- `start` during CALC or FIX is ignored.
- An operand change after `start` has no effect.
- Reset mid-operation aborts: IDLE, no `done`, outputs zeroed.

## Timing
- `start` sampled at edge T. Normal path:
  - CALC covers cycles T+1 .. T+N.
  - FIX is at T+N+1.
  - `done` is high in cycle T+N+2 (18 cycles wide, 10 cycles byte).
- `busy` = 1 in CALC and FIX, and 0 in IDLE and DONE.
- Error path (divide by zero or early overflow): `done` and `div_error` are high in cycle T+1; `busy` never rises.
- Back-to-back: a `start` sampled in the DONE cycle is accepted.

## Configuration
- `ALU_DIV_SIGNED_EN` defined:
  - signed division is supported as described.
- Not defined:
  - `signed_div` is ignored and every operation is DIVU.
  - The FIX state is still traversed for one cycle, so latency is unchanged.

## Test plan
- Wide unsigned: dividend 0x0001_0005, divisor 0x0002, `start` at T:
  - `done` at T+18, `quotient` = 0x8002, `remainder` = 0x0001, `div_error` = 0
  - `busy` high for T+1 .. T+17
- Byte unsigned: dividend 0x0064, divisor 0x0007:
  - `done` at T+10, `quotient` = 0x000E, `remainder` = 0x0002
- Wide signed: dividend 0xFFFF_FFF9, divisor 0x0002:
  - `quotient` = 0xFFFD, `remainder` = 0xFFFF
- Byte signed: dividend 0xFF80, divisor 0x01:
  - `quotient` = 0x0080, no error
- Signed range overflow: dividend 0x0080, divisor 0x01:
  - `done` at T+10 with `div_error` = 1, quotient unchanged
- Errors at T+1:
  - divisor 0x0000: `done` and `div_error` at T+1, `busy` stays 0
  - wide 0x0002_0000 / 0x0002 (early overflow): `done` and `div_error` at T+1, `busy` stays 0
- Aborts and ignored requests:
  - `start` pulses during CALC are ignored and the result equals the first request's result.
  - `reset_n` low during CALC: all outputs 0 immediately, no `done` afterwards.

Source files
------------

// File: rtl/alu_div.sv
// alu_div: sequential restoring divider (32/16 wide, 16/8 byte) for the execution unit.
// Signed DIV is available only when ALU_DIV_SIGNED_EN is defined; otherwise every request is DIVU.
module alu_div (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        signed_div,
  input  logic        wide,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_error,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic        wide_q;
  logic        sgn_q;
  logic        dvd_neg_q;
  logic        quo_neg_q;
  logic [4:0]  cnt_q;
  logic [15:0] dvs_q;
  logic [15:0] rem_q;
  logic [15:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] quo_q;
  logic [15:0] rmd_q;

  logic sgn_s;
`ifdef ALU_DIV_SIGNED_EN
  assign sgn_s = signed_div;
`else
  logic unused_signed_div_s;
  assign unused_signed_div_s = signed_div;
  assign sgn_s = 1'b0;
`endif

  logic        dvd_neg_s;
  logic        dvs_neg_s;
  logic        dvs_zero_s;
  logic        ovf_s;
  logic [31:0] dvd_mag_s;
  logic [15:0] dvs_mag_s;
  logic [15:0] hi_s;
  logic [15:0] lo_init_s;

  // Request decode: operand magnitudes plus the divide-by-zero and early overflow checks.
  always_comb begin
    dvd_neg_s = sgn_s & (wide ? dividend[31] : dividend[15]);
    dvs_neg_s = sgn_s & (wide ? divisor[15] : divisor[7]);
    if (wide) begin
      dvd_mag_s  = dvd_neg_s ? (32'd0 - dividend) : dividend;
      dvs_mag_s  = dvs_neg_s ? (16'd0 - divisor) : divisor;
      hi_s       = dvd_mag_s[31:16];
      lo_init_s  = dvd_mag_s[15:0];
      dvs_zero_s = (divisor == 16'd0);
    end else begin
      dvd_mag_s  = {16'd0, (dvd_neg_s ? (16'd0 - dividend[15:0]) : dividend[15:0])};
      dvs_mag_s  = {8'd0, (dvs_neg_s ? (8'd0 - divisor[7:0]) : divisor[7:0])};
      hi_s       = {8'd0, dvd_mag_s[15:8]};
      // Byte low half is left-aligned so both modes shift out of lo_q[15].
      lo_init_s  = {dvd_mag_s[7:0], 8'd0};
      dvs_zero_s = (divisor[7:0] == 8'd0);
    end
    ovf_s = (hi_s >= dvs_mag_s);
  end

  logic [16:0] shl_s;
  logic [16:0] diff_s;
  logic        qbit_s;
  logic [15:0] rem_d;
  logic [15:0] lo_d;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shl_s  = {rem_q, lo_q[15]};
    diff_s = shl_s - {1'b0, dvs_q};
    qbit_s = ~diff_s[16];
    rem_d  = qbit_s ? diff_s[15:0] : shl_s[15:0];
    lo_d   = {lo_q[14:0], qbit_s};
  end

  logic [15:0] qmag_s;
  logic [15:0] quo_fix_s;
  logic [15:0] rmd_fix_s;
  logic [15:0] lim_s;
  logic        range_err_s;

  // Sign fix-up and signed range check of the finished magnitudes.
  always_comb begin
    if (wide_q) begin
      qmag_s    = lo_q;
      quo_fix_s = quo_neg_q ? (16'd0 - lo_q) : lo_q;
      rmd_fix_s = dvd_neg_q ? (16'd0 - rem_q) : rem_q;
      lim_s     = 16'h8000;
    end else begin
      qmag_s    = {8'd0, lo_q[7:0]};
      quo_fix_s = {8'd0, (quo_neg_q ? (8'd0 - lo_q[7:0]) : lo_q[7:0])};
      rmd_fix_s = {8'd0, (dvd_neg_q ? (8'd0 - rem_q[7:0]) : rem_q[7:0])};
      lim_s     = 16'h0080;
    end
    if (!sgn_q) begin
      range_err_s = 1'b0;
    end else if (quo_neg_q) begin
      range_err_s = (qmag_s > lim_s);
    end else begin
      range_err_s = (qmag_s >= lim_s);
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wide_q    <= 1'b0;
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      cnt_q     <= 5'd0;
      dvs_q     <= 16'd0;
      rem_q     <= 16'd0;
      lo_q      <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      quo_q     <= 16'd0;
      rmd_q     <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            wide_q    <= wide;
            sgn_q     <= sgn_s;
            dvd_neg_q <= dvd_neg_s;
            quo_neg_q <= dvd_neg_s ^ dvs_neg_s;
            dvs_q     <= dvs_mag_s;
            rem_q     <= hi_s;
            lo_q      <= lo_init_s;
            if (dvs_zero_s || ovf_s) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
              cnt_q   <= wide ? 5'd16 : 5'd8;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= ST_FIX;
          end else begin
            state_q <= ST_CALC;
          end
        end
        ST_FIX: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (range_err_s) begin
            err_q <= 1'b1;
          end else begin
            quo_q <= quo_fix_s;
            rmd_q <= rmd_fix_s;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_error = err_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule
